// File: rtl/exe_stage_if.sv
// Execute-stage bundle interface: ID/EXE in, EXE/MEM out, PC redirect and counters.
// The slave modport is the execute stage; the master modport is the surrounding pipeline.
interface exe_stage_if #(
  parameter int unsigned CNT_W = 32
);
  logic             stall;
  logic [157:0]     in_bundle;
  logic [71:0]      out_mem;
  logic             redirect;
  logic             flush;
  logic [31:0]      target;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] ins_cnt;

  modport slave (
    input  stall, in_bundle,
    output out_mem, redirect, flush, target, br_cnt, ins_cnt
  );

  modport master (
    output stall, in_bundle,
    input  out_mem, redirect, flush, target, br_cnt, ins_cnt
  );
endinterface

// File: rtl/exe_stage.sv
// Execute stage: ALU, beq/j resolution with PC redirect, registered EXE/MEM bundle and
// taken-branch / executed-instruction counters.
module exe_stage #(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        clr,
  exe_stage_if.slave  bus
);

  logic        w_reg_write, w_mem_to_reg, w_mem_write, w_branch_eq, w_jump, w_alu_src, w_reg_dst;
  logic [2:0]  w_aluc;
  logic [4:0]  w_rt, w_rd, w_dst;
  logic [15:0] w_imm;
  logic [31:0] w_qa, w_qb, w_pc4, w_simm, w_a, w_b, w_alu;
  logic [25:0] w_adr26;
  logic        w_zero, w_take_b, w_take_j, w_redirect, w_count_ins;
  logic [31:0] w_target;
  logic [71:0] w_mem_d;

  logic [71:0]      r_out_mem;
  logic [CNT_W-1:0] r_br_cnt, r_ins_cnt;

  assign w_reg_write  = bus.in_bundle[0];
  assign w_mem_to_reg = bus.in_bundle[1];
  assign w_mem_write  = bus.in_bundle[2];
  assign w_branch_eq  = bus.in_bundle[3];
  assign w_jump       = bus.in_bundle[4];
  assign w_alu_src    = bus.in_bundle[5];
  assign w_reg_dst    = bus.in_bundle[6];
  assign w_aluc       = bus.in_bundle[9:7];
  assign w_rt         = bus.in_bundle[14:10];
  assign w_rd         = bus.in_bundle[19:15];
  assign w_imm        = bus.in_bundle[35:20];
  assign w_qa         = bus.in_bundle[67:36];
  assign w_qb         = bus.in_bundle[99:68];
  assign w_pc4        = bus.in_bundle[131:100];
  assign w_adr26      = bus.in_bundle[157:132];

  assign w_simm = {{16{w_imm[15]}}, w_imm};
  assign w_a    = w_qa;
  assign w_b    = w_alu_src ? w_simm : w_qb;
  assign w_dst  = w_reg_dst ? w_rd : w_rt;

  always_comb begin
    w_alu = '0;
    unique case (w_aluc)
      3'b000: w_alu = w_a + w_b;
      3'b001: w_alu = w_a - w_b;
      3'b010: w_alu = w_a & w_b;
      3'b011: w_alu = w_a | w_b;
      3'b100: w_alu = w_a ^ w_b;
      3'b101: w_alu = {31'd0, $signed(w_a) < $signed(w_b)};
      3'b110: w_alu = w_b << w_imm[10:6];
      3'b111: w_alu = {w_imm, 16'h0000};
      default: w_alu = '0;
    endcase
  end

  // Branch compare always uses the register pair, regardless of ALUSrc.
  assign w_zero     = (w_qa == w_qb);
  assign w_take_b   = w_branch_eq & w_zero;
  assign w_take_j   = w_jump;
  assign w_redirect = (w_take_b | w_take_j) & ~bus.stall & ~clr;

  always_comb begin
    w_target = w_pc4;
    if (w_take_j) begin
      w_target = {w_pc4[31:28], w_adr26, 2'b00};
    end else if (w_take_b) begin
      w_target = w_pc4 + {w_simm[29:0], 2'b00};
    end
  end

  assign w_count_ins = w_reg_write | w_mem_write | w_branch_eq | w_jump;
  assign w_mem_d     = {w_qb, w_alu, w_dst, w_mem_write, w_mem_to_reg, w_reg_write};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_out_mem <= '0;
      r_br_cnt  <= '0;
      r_ins_cnt <= '0;
    end else if (!bus.stall) begin
      r_out_mem <= w_mem_d;
      if (w_redirect) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (w_count_ins) r_ins_cnt <= r_ins_cnt + CNT_W'(1);
    end
  end

  assign bus.out_mem  = r_out_mem;
  assign bus.redirect = w_redirect;
  assign bus.flush    = w_redirect;
  assign bus.target   = w_target;
  assign bus.br_cnt   = r_br_cnt;
  assign bus.ins_cnt  = r_ins_cnt;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: hand-computed vectors for ALU, beq/j redirect, stall and clr.
module tb_exe_stage;

  localparam logic [6:0] RW = 7'h01, M2R = 7'h02, MW = 7'h04, BEQ = 7'h08, JMP = 7'h10,
                         ASRC = 7'h20, RDST = 7'h40;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  exe_stage_if #(.CNT_W(32)) bus ();

  exe_stage #(.CNT_W(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [157:0] mk(input logic [6:0] ctrl, input logic [2:0] aluc,
                                      input logic [4:0] rt, input logic [4:0] rd,
                                      input logic [15:0] imm, input logic [31:0] qa,
                                      input logic [31:0] qb, input logic [31:0] pc4,
                                      input logic [25:0] adr);
    return {adr, pc4, qb, qa, imm, rd, rt, aluc, ctrl};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.stall     = 1'b0;
    bus.in_bundle = '0;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
    #1;
    check("rst_out_mem", bus.out_mem, 72'h0);
    check("rst_br_cnt", 72'(bus.br_cnt), 72'd0);
    check("rst_ins_cnt", 72'(bus.ins_cnt), 72'd0);
    check("rst_redirect", 72'(bus.redirect), 72'd0);

    // addi r8 = 5 + (-3)
    bus.in_bundle = mk(RW | ASRC, 3'b000, 5'd8, 5'd0, 16'hFFFD, 32'd5, 32'h33, 32'h0, 26'h0);
    #1;
    check("addi_redirect", 72'(bus.redirect), 72'd0);
    edge_step();
    check("addi_out_mem", bus.out_mem, {32'h33, 32'd2, 5'd8, 3'b001});
    check("addi_ins_cnt", 72'(bus.ins_cnt), 72'd1);

    // beq taken, backwards offset -1 word
    bus.in_bundle = mk(BEQ, 3'b001, 5'd0, 5'd0, 16'hFFFF, 32'd7, 32'd7, 32'h100, 26'h0);
    #1;
    check("beq_redirect", 72'(bus.redirect), 72'd1);
    check("beq_flush", 72'(bus.flush), 72'd1);
    check("beq_target", 72'(bus.target), 72'hFC);
    edge_step();
    check("beq_br_cnt", 72'(bus.br_cnt), 72'd1);
    check("beq_out_mem", bus.out_mem, {32'd7, 32'd0, 5'd0, 3'b000});

    // beq not taken
    bus.in_bundle = mk(BEQ, 3'b001, 5'd0, 5'd0, 16'hFFFF, 32'd7, 32'd8, 32'h100, 26'h0);
    #1;
    check("bne_redirect", 72'(bus.redirect), 72'd0);
    edge_step();
    check("bne_br_cnt", 72'(bus.br_cnt), 72'd1);
    check("bne_ins_cnt", 72'(bus.ins_cnt), 72'd3);

    // jump
    bus.in_bundle = mk(JMP, 3'b000, 5'd0, 5'd0, 16'h0, 32'd0, 32'd0, 32'h40000010, 26'h0000123);
    #1;
    check("j_redirect", 72'(bus.redirect), 72'd1);
    check("j_target", 72'(bus.target), 72'h4000048C);
    edge_step();
    check("j_br_cnt", 72'(bus.br_cnt), 72'd2);

    // jump + taken beq: jump target wins
    bus.in_bundle = mk(JMP | BEQ, 3'b000, 5'd0, 5'd0, 16'h0010, 32'd3, 32'd3, 32'h40000010,
                       26'h0000123);
    #1;
    check("jb_target", 72'(bus.target), 72'h4000048C);
    check("jb_redirect", 72'(bus.redirect), 72'd1);
    edge_step();
    check("jb_br_cnt", 72'(bus.br_cnt), 72'd3);
    check("jb_ins_cnt", 72'(bus.ins_cnt), 72'd5);
    check("jb_out_mem", bus.out_mem, {32'd3, 32'd6, 5'd0, 3'b000});

    // stall with a taken beq pending
    bus.stall     = 1'b1;
    bus.in_bundle = mk(BEQ, 3'b001, 5'd0, 5'd0, 16'h0002, 32'd9, 32'd9, 32'h200, 26'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_redirect", 72'(bus.redirect), 72'd0);
      check("stall_flush", 72'(bus.flush), 72'd0);
      edge_step();
      check("stall_out_mem", bus.out_mem, {32'd3, 32'd6, 5'd0, 3'b000});
      check("stall_br_cnt", 72'(bus.br_cnt), 72'd3);
      check("stall_ins_cnt", 72'(bus.ins_cnt), 72'd5);
    end
    bus.stall = 1'b0;
    #1;
    check("unstall_redirect", 72'(bus.redirect), 72'd1);
    check("unstall_target", 72'(bus.target), 72'h208);
    edge_step();
    check("unstall_br_cnt", 72'(bus.br_cnt), 72'd4);
    check("unstall_ins_cnt", 72'(bus.ins_cnt), 72'd6);
    check("unstall_out_mem", bus.out_mem, {32'd9, 32'd0, 5'd0, 3'b000});
    bus.in_bundle = '0;
    #1;
    check("post_redirect", 72'(bus.redirect), 72'd0);

    // ALU sweep, qa = 0x80000000, qb = 1, dst = Rd = 3
    bus.in_bundle = mk(RW | RDST, 3'b101, 5'd9, 5'd3, 16'h0, 32'h80000000, 32'd1, 32'h0, 26'h0);
    edge_step();
    check("slt", 72'(bus.out_mem[39:8]), 72'd1);
    check("slt_dst", 72'(bus.out_mem[7:3]), 72'd3);
    bus.in_bundle = mk(RW | RDST, 3'b001, 5'd9, 5'd3, 16'h0, 32'h80000000, 32'd1, 32'h0, 26'h0);
    edge_step();
    check("sub", 72'(bus.out_mem[39:8]), 72'h7FFFFFFF);
    bus.in_bundle = mk(RW | RDST, 3'b100, 5'd9, 5'd3, 16'h0, 32'h80000000, 32'd1, 32'h0, 26'h0);
    edge_step();
    check("xor", 72'(bus.out_mem[39:8]), 72'h80000001);
    bus.in_bundle = mk(RW | RDST, 3'b110, 5'd9, 5'd3, 16'h0100, 32'h80000000, 32'd1, 32'h0,
                       26'h0);
    edge_step();
    check("sll", 72'(bus.out_mem[39:8]), 72'h10);
    bus.in_bundle = mk(RW | M2R | MW, 3'b111, 5'd9, 5'd3, 16'hABCD, 32'h80000000, 32'd1, 32'h0,
                       26'h0);
    edge_step();
    check("lui", bus.out_mem, {32'd1, 32'hABCD0000, 5'd9, 3'b111});
    check("sweep_ins_cnt", 72'(bus.ins_cnt), 72'd11);

    // bubble
    bus.in_bundle = '0;
    edge_step();
    check("bubble_out_mem", bus.out_mem, 72'h0);
    check("bubble_ins_cnt", 72'(bus.ins_cnt), 72'd11);
    check("bubble_br_cnt", 72'(bus.br_cnt), 72'd4);

    // asynchronous clr mid-operation
    bus.in_bundle = mk(BEQ | RW, 3'b000, 5'd1, 5'd0, 16'h0, 32'd4, 32'd4, 32'h300, 26'h0);
    edge_step();
    #2;
    clr = 1'b1;
    #1;
    check("clr_out_mem", bus.out_mem, 72'h0);
    check("clr_br_cnt", 72'(bus.br_cnt), 72'd0);
    check("clr_ins_cnt", 72'(bus.ins_cnt), 72'd0);
    check("clr_redirect", 72'(bus.redirect), 72'd0);
    bus.in_bundle = '0;
    edge_step();
    clr = 1'b0;
    edge_step();
    check("after_clr_out_mem", bus.out_mem, 72'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/exe_stage.md
Name: exe_stage

Overview:
- Execute stage of the 5-stage pipelined CPU.
- Consumes the 158-bit ID/EXE bundle each cycle. Performs the ALU operation and resolves beq/j.
- Drives the PC redirect and flush request back to IF/ID and ID/EXE.
- Registers a 72-bit EXE/MEM bundle for the memory stage. Also keeps taken-branch and executed-instruction counters.

Parameters:
- CNT_W, 32, width of the performance counters.

Ports:
- clk  input  1  clock
- clr  input  1  reset
- stall  input  1  MEM-side hold; freezes out_mem and the counters
- in_bundle  input  158  ID/EXE bundle (layout below)
- out_mem  output  72  registered EXE/MEM bundle
- redirect  output  1  combinational; PC must load `target` on the next edge
- flush  output  1  combinational; equals `redirect`; clears IF/ID and ID/EXE
- target  output  32  combinational redirect address
- br_cnt  output  CNT_W  count of taken beq/j
- ins_cnt  output  CNT_W  count of executed non-bubble instructions

Behaviour:
- Interface: reset clr, asynchronous, active-high; clock clk.
- in_bundle layout:
  - [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] BranchEq, [4] Jump, [5] ALUSrc, [6] RegDst
  - [9:7] ALUc, [14:10] Rt, [19:15] Rd, [35:20] imm16
  - [67:36] qa, [99:68] qb, [131:100] pc4, [157:132] adr26
  - An all-zero bundle is a bubble.
- Operands:
  - simm = sign-extend(imm16) to 32 bits.
  - A = qa; B = ALUSrc ? simm : qb.
- ALUc encoding (results are 32-bit, wrap, no overflow trap):
  - 000 A+B
  - 001 A−B
  - 010 A&B
  - 011 A|B
  - 100 A^B
  - 101 signed(A)<signed(B) ? 1 : 0
  - 110 B << imm16[10:6]
  - 111 {imm16, 16'h0}
- zero = (qa − qb == 0); always compares the registers, independent of ALUSrc.
- dst = RegDst ? Rd : Rt.
- Branch resolution:
  - take_b = BranchEq & zero; take_j = Jump.
  - redirect = (take_b | take_j) & ~stall.
  - Jump has priority over branch when both bits are set.
  - target when take_j: {pc4[31:28], adr26, 2'b00}.
  - target when take_b: pc4 + (simm << 2), 32-bit wrap.
  - target otherwise: pc4, a don't-care but deterministic value.
- out_mem layout: [0] RegWrite, [1] MemToReg, [2] MemWrite, [7:3] dst, [39:8] ALU result, [71:40] qb (store data).
- out_mem register, one cycle of latency:
  - clr high: 0 asynchronously.
  - stall high: hold.
  - Otherwise: load the new bundle.
- Branch and jump instructions pass RegWrite/MemWrite straight through from the decoder, which drives them 0.
- Counters, updated only when not stalled:
  - br_cnt += 1 when redirect.
  - ins_cnt += 1 when any of bits [0],[2],[3],[4] is set.
  - Both wrap at 2^CNT_W and reset to 0 on clr.
- Stall with a pending branch:
  - redirect stays low while stall is high.
  - redirect asserts in the first cycle stall is low with the bundle still present, so exactly one redirect is issued per branch.
- clr mid-operation:
  - All outputs return to 0 immediately.
  - redirect/flush are 0 while in_bundle is also zeroed upstream by the same clr.
- An in_bundle of all zeros produces out_mem = 0 with ALU result 0 (ALUc 000, 0+0); no redirect; no counter change.

Test Plan:
- Reset: clr=1 for 2 cycles, then release → out_mem=0, br_cnt=ins_cnt=0, redirect=0.
- addi: qa=5, imm16=16'hFFFD, ALUSrc=1, RegWrite=1, Rt=8, RegDst=0 → next edge: out_mem[39:8]=2, dst=8, bit0=1; ins_cnt=1.
- beq taken: qa=qb=7, BranchEq=1, pc4=0x100, imm16=0xFFFF → same cycle: redirect=flush=1, target=0xFC; next edge: br_cnt=1. With qb=8 → redirect=0.
- Jump: Jump=1, pc4=0x40000010, adr26=0x0000123 → target=0x4000048C, redirect=1. BranchEq=1 also set with zero=1 → jump target still used.
- Stall: hold stall=1 for 3 cycles with a taken beq present → out_mem unchanged, redirect=0, counters frozen. Drop stall → exactly one redirect cycle; br_cnt +1.
- ALU sweep: qa=0x80000000, qb=1:
  - slt → 1; sub → 0x7FFFFFFF; xor → 0x80000001.
  - sll with imm16[10:6]=4 (ALUSrc=0, B=qb) → 0x10.
  - lui with imm16=0xABCD → 0xABCD0000.
